// File: rtl/fp_to_int_seq.sv
// Serial floating-point to signed integer converter. The fraction is shifted into
// an integer accumulator one bit per clock, then rounded, signed and saturated.
module fp_to_int_seq #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8,
  parameter int INT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    rnd_mode,
  input  logic [EXP_W+FRAC_W:0]   fp,
  output logic                    ready,
  output logic                    done_tick,
  output logic [INT_W-1:0]        int_val,
  output logic                    uf,
  output logic                    of
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIX} state_t;

  localparam logic [INT_W:0]   POS_LIM = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0]   NEG_LIM = {2'b01, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] SAT_POS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SAT_NEG = {1'b1, {(INT_W-1){1'b0}}};

  state_t            state, state_nx;
  logic              sgn, rnd, ovf_s, frac_nz;
  logic [FRAC_W-1:0] frac_reg;
  logic [EXP_W-1:0]  cnt;
  logic [INT_W-1:0]  acc;

  logic [EXP_W-1:0]  fp_exp;
  logic [FRAC_W-1:0] fp_frac;
  logic              rbit, of_nx, uf_nx;
  logic [INT_W:0]    mag;
  logic [INT_W-1:0]  int_nx;

  assign fp_exp  = fp[EXP_W+FRAC_W-1:FRAC_W];
  assign fp_frac = fp[FRAC_W-1:0];
  assign ready   = (state == IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = (fp_exp != '0) ? SHIFT : FIX;
      // A set acc MSB is about to fall off: the result is saturated, stop early.
      SHIFT: if (cnt == EXP_W'(1) || acc[INT_W-1]) state_nx = FIX;
      FIX:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rbit   = rnd & frac_reg[FRAC_W-1];
    mag    = {1'b0, acc} + {{INT_W{1'b0}}, rbit};
    of_nx  = ovf_s | (~sgn & (mag > POS_LIM)) | (sgn & (mag > NEG_LIM));
    int_nx = mag[INT_W-1:0];
    if (of_nx)    int_nx = sgn ? SAT_NEG : SAT_POS;
    else if (sgn) int_nx = ~mag[INT_W-1:0] + INT_W'(1);
    uf_nx  = frac_nz & (mag == '0) & ~of_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sgn      <= 1'b0;
      rnd      <= 1'b0;
      ovf_s    <= 1'b0;
      frac_nz  <= 1'b0;
      frac_reg <= '0;
      cnt      <= '0;
      acc      <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start) begin
          sgn      <= fp[EXP_W+FRAC_W];
          rnd      <= rnd_mode;
          frac_reg <= fp_frac;
          frac_nz  <= (fp_frac != '0);
          cnt      <= fp_exp;
          acc      <= '0;
          ovf_s    <= 1'b0;
        end
        SHIFT: begin
          acc      <= {acc[INT_W-2:0], frac_reg[FRAC_W-1]};
          frac_reg <= {frac_reg[FRAC_W-2:0], 1'b0};
          cnt      <= cnt - EXP_W'(1);
          if (acc[INT_W-1]) ovf_s <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_tick <= 1'b0;
      int_val   <= '0;
      uf        <= 1'b0;
      of        <= 1'b0;
    end else begin
      done_tick <= (state == FIX);
      if (state == FIX) begin
        int_val <= int_nx;
        uf      <= uf_nx;
        of      <= of_nx;
      end
    end
  end

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Scoreboard bench for fp_to_int_seq: expected results are queued at launch and
// popped by a monitor on each done_tick; latency and control cases checked inline.
module tb_fp_to_int_seq;
  localparam int EXP_W = 4, FRAC_W = 8, INT_W = 8;

  logic                  clk = 1'b0, reset_n = 1'b0, start = 1'b0, rnd_mode = 1'b0;
  logic [EXP_W+FRAC_W:0] fp = '0;
  logic                  ready, done_tick, uf, of;
  logic [INT_W-1:0]      int_val;

  fp_to_int_seq #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .INT_W(INT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rnd_mode(rnd_mode), .fp(fp),
    .ready(ready), .done_tick(done_tick), .int_val(int_val), .uf(uf), .of(of));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] iv; logic uf; logic of; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int vectors = 0, miscompares = 0;

  always @(negedge clk) if (reset_n && done_tick) begin
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL done_unexpected: done_tick=1 with no conversion pending");
    end else begin
      mon_e = sb.pop_front();
      if ({int_val, uf, of} !== {mon_e.iv, mon_e.uf, mon_e.of}) begin
        miscompares++;
        $display("FAIL result: int=%h uf=%b of=%b, expected int=%h uf=%b of=%b",
                 int_val, uf, of, mon_e.iv, mon_e.uf, mon_e.of);
      end
    end
  end

  function automatic exp_t mk(input logic [7:0] iv, input logic u, input logic o);
    exp_t r; r.iv = iv; r.uf = u; r.of = o; return r;
  endfunction

  // Arithmetic reference: integer part and first dropped bit of 0.frac * 2^e.
  function automatic exp_t model(input bit s, input int e, input int f, input bit r,
                                 output int lat);
    exp_t   x;
    longint big, ipart, mag;
    int     p;
    big   = longint'(f) << e;
    ipart = big >> FRAC_W;
    mag   = ipart + ((r && big[FRAC_W-1]) ? 1 : 0);
    x.of  = s ? (mag > 128) : (mag > 127);
    x.iv  = x.of ? (s ? 8'h80 : 8'h7F) : (s ? 8'(-mag) : 8'(mag));
    x.uf  = (f != 0) && (mag == 0) && !x.of;
    p = 0;
    while (p < FRAC_W && f[FRAC_W-1-p] == 1'b0) p++;
    lat = (f != 0 && e >= INT_W + 1 + p) ? INT_W + 2 + p : e + 1;
    return x;
  endfunction

  task automatic launch(input bit s, input logic [3:0] e, input logic [7:0] f,
                        input bit r, input exp_t ev);
    @(negedge clk);
    fp = {s, e, f}; rnd_mode = r; start = 1'b1;
    sb.push_back(ev);
    @(posedge clk); #1;
    start = 1'b0;
    fp = 13'($urandom); rnd_mode = 1'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1; n++;
      if (done_tick) return;
    end
    n = -1;
  endtask

  task automatic test_reset;
    #12;
    vectors++;
    if ({int_val, uf, of, done_tick, ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset: int=%h uf=%b of=%b done=%b ready=%b, expected 00 0 0 0 1",
               int_val, uf, of, done_tick, ready);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_defaults;
    launch(0, 3, 8'hA0, 0, mk(8'h05, 0, 0));
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_busy: ready=%b before edge E0+%0d, expected 0", ready, i);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (done_tick !== 1'b1 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL defaults_latency: done=%b ready=%b at E0+4, expected 1 1", done_tick, ready);
    end
  endtask

  task automatic test_rounding;
    int n;
    launch(0, 2, 8'hA0, 0, mk(8'h02, 0, 0)); wait_done(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL round_trunc_lat: %0d expected 3", n); end
    launch(0, 2, 8'hA0, 1, mk(8'h03, 0, 0)); wait_done(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL round_half_lat: %0d expected 3", n); end
    launch(1, 2, 8'hA0, 1, mk(8'hFD, 0, 0)); wait_done(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL round_neg_lat: %0d expected 3", n); end
  endtask

  task automatic test_underflow;
    int n;
    launch(0, 0, 8'hA0, 0, mk(8'h00, 1, 0)); wait_done(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL uf_lat: %0d expected 1", n); end
    launch(0, 0, 8'hA0, 1, mk(8'h01, 0, 0)); wait_done(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL uf_round_lat: %0d expected 1", n); end
  endtask

  task automatic test_saturation;
    int n;
    launch(0, 8, 8'h80, 0, mk(8'h7F, 0, 1)); wait_done(n);
    vectors++; if (n !== 9) begin miscompares++; $display("FAIL sat_pos_lat: %0d expected 9", n); end
    launch(1, 8, 8'h80, 0, mk(8'h80, 0, 0)); wait_done(n);
    vectors++; if (n !== 9) begin miscompares++; $display("FAIL sat_neg_lat: %0d expected 9", n); end
    launch(1, 15, 8'hFF, 0, mk(8'h80, 0, 1)); wait_done(n);
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL early_exit_lat: %0d expected 10", n); end
  endtask

  task automatic test_sweep;
    int n, lat;
    exp_t ev;
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 2; r++)
        for (int e = 0; e < 16; e++) begin
          ev = model(s[0], e, 8'hA0, r[0], lat);
          launch(s[0], 4'(e), 8'hA0, r[0], ev);
          wait_done(n);
          vectors++;
          if (n !== lat) begin
            miscompares++;
            $display("FAIL sweep_lat s=%0d r=%0d e=%0d: %0d expected %0d", s, r, e, n, lat);
          end
        end
  endtask

  task automatic test_busy_start;
    int n, lat;
    launch(0, 5, 8'hA0, 0, model(0, 5, 8'hA0, 0, lat));
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL busy_ready: %b expected 0", ready); end
    start = 1'b1; fp = {1'b0, 4'd1, 8'hFF};
    @(posedge clk); #1; start = 1'b0;
    wait_done(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL busy_lat: %0d expected 3", n); end
    repeat (12) @(posedge clk); #1;
    vectors++;
    if (sb.size() !== 0) begin miscompares++; $display("FAIL busy_pending: %0d expected 0", sb.size()); end
  endtask

  task automatic test_zero_frac;
    int n;
    launch(0, 5, 8'h00, 1, mk(8'h00, 0, 0)); wait_done(n);
    vectors++; if (n !== 6) begin miscompares++; $display("FAIL zero_lat: %0d expected 6", n); end
  endtask

  task automatic test_reset_mid;
    int lat;
    launch(0, 7, 8'hA0, 0, model(0, 7, 8'hA0, 0, lat));
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0; #1;
    vectors++;
    if ({int_val, uf, of, done_tick, ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_mid: int=%h uf=%b of=%b done=%b ready=%b, expected 00 0 0 0 1",
               int_val, uf, of, done_tick, ready);
    end
    sb.delete();
    @(negedge clk); reset_n = 1'b1;
    repeat (12) @(posedge clk); #1;
    vectors++;
    if (int_val !== 8'h00) begin miscompares++; $display("FAIL reset_mid_hold: int=%h expected 00", int_val); end
  endtask

  task automatic test_back_to_back;
    int n;
    launch(0, 3, 8'hA0, 0, mk(8'h05, 0, 0)); wait_done(n);
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL b2b_first_lat: %0d expected 4", n); end
    fp = {1'b1, 4'd2, 8'hA0}; rnd_mode = 1'b1; start = 1'b1;
    sb.push_back(mk(8'hFD, 0, 0));
    @(posedge clk); #1; start = 1'b0;
    wait_done(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL b2b_second_lat: %0d expected 3", n); end
  endtask

  initial begin
    test_reset;
    test_defaults;
    test_rounding;
    test_underflow;
    test_saturation;
    test_sweep;
    test_busy_start;
    test_zero_frac;
    test_reset_mid;
    test_back_to_back;
    repeat (4) @(posedge clk); #1;
    vectors++;
    if (sb.size() !== 0) begin miscompares++; $display("FAIL final_pending: %0d expected 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fp_to_int_seq.md
Name: fp_to_int_seq

Overview:
Parametrised, sequential successor to the combinational 13-bit floating-point to 8-bit integer converter. It accepts a sign/exponent/fraction word through a start/ready handshake and serially shifts the fraction into an integer accumulator, one bit per clock. It then applies a selectable rounding mode, sign and saturation, and reports underflow and overflow with a one-cycle done_tick. It sits between the fp datapath and integer consumers where area matters more than latency.

Parameters:
EXP_W, 4, exponent width (unsigned exponent e).
FRAC_W, 8, fraction width; value = (-1)^s * 0.frac * 2^e.
INT_W, 8, signed two's-complement result width (INT_W >= 2).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only while ready=1.
rnd_mode  in  1  0 = truncate toward zero, 1 = round half away from zero; sampled with start.
fp  in  1+EXP_W+FRAC_W  {sign, exp, frac}; sampled with start.
ready  out  1  high in IDLE only (combinational from state).
done_tick  out  1  one-cycle pulse; int/uf/of are updated on the same edge.
int  out  INT_W  signed result; held until the next done_tick.
uf  out  1  underflow flag; held until the next done_tick.
of  out  1  overflow flag; held until the next done_tick.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset (asynchronous, any state): state=IDLE, int=0, uf=0, of=0, done_tick=0, all internal registers cleared. A conversion in flight is discarded, with no done_tick.
- Registers: sgn, rnd, frac_reg (FRAC_W), cnt (EXP_W), acc (INT_W, unsigned magnitude), ovf_s (sticky).
- IDLE: start=1 at edge E0 loads the registers, acc=0, ovf_s=0. Next state is SHIFT if exp>0, otherwise FIX. start=0 keeps the block in IDLE.
- SHIFT (one edge per exponent step):
  - acc <= {acc[INT_W-2:0], frac_reg[MSB]}; frac_reg <<= 1 (zero fill); cnt <= cnt-1.
  - ovf_s sets if acc[INT_W-1]=1 before the shift, i.e. a magnitude bit is lost.
  - Leave to FIX when cnt reaches 1 or when ovf_s is being set (early exit).
- FIX (single edge):
  - rbit = frac_reg[MSB] if rnd=1, else 0. mag = acc + rbit, computed INT_W+1 bits wide.
  - of = ovf_s | (sgn=0 & mag > 2^(INT_W-1)-1) | (sgn=1 & mag > 2^(INT_W-1)).
  - int = of ? (sgn ? -2^(INT_W-1) : 2^(INT_W-1)-1) : (sgn ? -mag : mag). A zero result is 0 for both signs.
  - uf = (frac != 0) & (mag == 0) & ~of. frac=0 gives int=0, uf=0, of=0.
  - Assert done_tick; return to IDLE.
- Latency: done_tick at edge E0+e+1 without early exit; at E0+k+1 when the overflow is detected on shift k. Throughput is one conversion per e+2 cycles.
- start while busy (ready=0) is ignored, with no queueing. start in the cycle done_tick is high is accepted, because the state is IDLE.
- When e exceeds FRAC_W, zeros shift in and the round bit is 0.
- The fp input may change freely after E0; the converter works only from its registered copy.

Test Plan:
1. Defaults. fp={0,3,10100000} (5.0), rnd_mode=0 -> done_tick at E0+4, int=0x05, uf=0, of=0; ready low for edges E0+1..E0+4.
2. fp={0,2,10100000} (2.5): rnd_mode=0 -> 0x02; rnd_mode=1 -> 0x03. fp={1,2,10100000}, rnd_mode=1 -> 0xFD (-3).
3. fp={0,0,10100000} (0.625): rnd_mode=0 -> int=0x00, uf=1, done_tick at E0+1; rnd_mode=1 -> 0x01, uf=0.
4. fp={0,8,10000000} (128) -> int=0x7F, of=1. fp={1,8,10000000} -> int=0x80, of=0, uf=0.
5. fp={1,15,11111111} -> early exit, ovf_s set on shift 9, done_tick at E0+10 (not E0+16), int=0x80, of=1. Sweep all 16 exponents for frac=10100000 and both signs against a reference model.
6. Control cases:
   - start pulsed mid-SHIFT -> ignored.
   - reset_n low mid-SHIFT -> outputs 0, IDLE, no done_tick.
   - fp={0,5,00000000} -> int=0, uf=0, of=0.
   - Back-to-back start on a done_tick cycle -> accepted.
